// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: run/step/halt sequencer for the CPU clock.
//
// One push button drives everything. A short press issues one CPU clock
// period while halted. A long press toggles between run and halt. An address
// breakpoint can also stop a running CPU at the end of a period.
//
// Ports:
//   sysclk    - system clock, all logic on posedge
//   rst_n     - asynchronous active-low reset, synchronous release
//   btn       - raw push button, active high, asynchronous
//   bp_en     - breakpoint enable
//   bp_addr   - breakpoint address
//   bus_addr  - current CPU bus address
//   cpu_clk   - registered CPU clock
//   cpu_tick  - one sysclk pulse in the cycle cpu_clk rises
//   running   - high while in RUN mode (aligned with cpu_clk)
//   halted_bp - set by a breakpoint halt, cleared on resume/step
//   step_cnt  - number of CPU clock periods issued (wraps)
//
// Internal handshakes (toggle_req, step_req) are single-cycle pulses with no
// ready: the mode FSM samples them in the cycle they are high, or drops them.
module cpu_clk_ctrl #(
  parameter int TICK_DIV        = 65536,
  parameter int DEBOUNCE_TICKS  = 41,
  parameter int LONGPRESS_TICKS = 824,
  parameter int RUN_DIV         = 4,
  parameter int AUTORUN         = 1,
  parameter int ADDR_W          = 16
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              btn,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              cpu_clk,
  output logic              cpu_tick,
  output logic              running,
  output logic              halted_bp,
  output logic [15:0]       step_cnt
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(LONGPRESS_TICKS + 1);
  localparam int DW = $clog2(RUN_DIV);

  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_TICKS - 1);
  localparam logic [BW-1:0] DEB_FULL = BW'(DEBOUNCE_TICKS);
  localparam logic [BW-1:0] LP_LAST  = BW'(LONGPRESS_TICKS - 1);
  localparam logic [DW-1:0] D_MAX    = DW'(RUN_DIV - 1);
  localparam logic [DW-1:0] D_HALF   = DW'(RUN_DIV / 2);

  typedef enum logic [1:0] {BTN_UP, BTN_DOWN, BTN_LONG} btn_state_t;
  typedef enum logic [1:0] {M_RUN, M_HALT, M_STEP} mode_t;

  // ---------------- button synchroniser and sampling tick ----------------
  logic          btn_meta, btn_s;
  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PRE_MAX);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      pre_q    <= '0;
    end else begin
      btn_meta <= btn;
      btn_s    <= btn_meta;
      pre_q    <= tick ? '0 : pre_q + PW'(1);
    end
  end

  // ---------------- button FSM ----------------
  // stab_q counts consecutive ticks at the level that would cause the next
  // transition. hold_q counts pressed ticks, including the debounce ticks,
  // so a long press is measured from the first stable pressed sample.
  btn_state_t    btn_state, btn_next;
  logic [BW-1:0] stab_q, stab_d, hold_q, hold_d;
  logic          toggle_req, step_req;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_state <= BTN_UP;
      stab_q    <= '0;
      hold_q    <= '0;
    end else begin
      btn_state <= btn_next;
      stab_q    <= stab_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    btn_next   = btn_state;
    stab_d     = stab_q;
    hold_d     = hold_q;
    toggle_req = 1'b0;
    step_req   = 1'b0;
    if (tick) begin
      case (btn_state)
        BTN_UP: begin
          if (!btn_s) begin
            stab_d = '0;
          end else if (stab_q == DEB_LAST) begin
            btn_next = BTN_DOWN;
            stab_d   = '0;
            hold_d   = DEB_FULL;
          end else begin
            stab_d = stab_q + BW'(1);
          end
        end
        BTN_DOWN: begin
          if (btn_s) begin
            stab_d = '0;
            if (hold_q == LP_LAST) begin
              toggle_req = 1'b1;
              btn_next   = BTN_LONG;
              hold_d     = '0;
            end else begin
              hold_d = hold_q + BW'(1);
            end
          end else if (stab_q == DEB_LAST) begin
            step_req = 1'b1;
            btn_next = BTN_UP;
            stab_d   = '0;
            hold_d   = '0;
          end else begin
            stab_d = stab_q + BW'(1);
          end
        end
        BTN_LONG: begin
          if (btn_s) begin
            stab_d = '0;
          end else if (stab_q == DEB_LAST) begin
            btn_next = BTN_UP;
            stab_d   = '0;
          end else begin
            stab_d = stab_q + BW'(1);
          end
        end
        default: begin
          btn_next = BTN_UP;
          stab_d   = '0;
          hold_d   = '0;
        end
      endcase
    end
  end

  // ---------------- mode FSM ----------------
  // d_q is the phase that the next cpu_clk register update will present, so
  // every output is registered and a period always starts at phase 0.
  mode_t         mode_q, mode_d;
  logic [DW-1:0] d_q, d_d;
  logic          pend_q, pend_d;   // toggle seen in RUN, waiting for period end
  logic          mask_q, mask_d;   // skip the first compare after a resume
  logic          hbp_d;
  logic          active, last, bp_hit;

  assign active = (mode_q == M_RUN) || (mode_q == M_STEP);
  assign last   = (d_q == D_MAX);
  assign bp_hit = bp_en && (bus_addr == bp_addr);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= (AUTORUN != 0) ? M_RUN : M_HALT;
      d_q       <= '0;
      pend_q    <= 1'b0;
      mask_q    <= 1'b0;
      halted_bp <= 1'b0;
      cpu_clk   <= 1'b0;
      cpu_tick  <= 1'b0;
      running   <= (AUTORUN != 0);
      step_cnt  <= '0;
    end else begin
      mode_q    <= mode_d;
      d_q       <= d_d;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      halted_bp <= hbp_d;
      cpu_clk   <= active && (d_q < D_HALF);
      cpu_tick  <= active && (d_q == '0);
      running   <= (mode_q == M_RUN);
      if (active && (d_q == '0)) step_cnt <= step_cnt + 16'd1;
    end
  end

  always_comb begin
    mode_d = mode_q;
    d_d    = d_q;
    pend_d = pend_q;
    mask_d = mask_q;
    hbp_d  = halted_bp;
    case (mode_q)
      M_RUN: begin
        d_d = last ? '0 : d_q + DW'(1);
        if (toggle_req) pend_d = 1'b1;
        if (last) begin
          mask_d = 1'b0;
          pend_d = 1'b0;
          // A breakpoint hit wins over a pending toggle so halted_bp is set.
          if (!mask_q && bp_hit) begin
            mode_d = M_HALT;
            hbp_d  = 1'b1;
          end else if (pend_q || toggle_req) begin
            mode_d = M_HALT;
          end
        end
      end
      M_HALT: begin
        d_d    = '0;
        pend_d = 1'b0;
        if (toggle_req) begin
          mode_d = M_RUN;
          hbp_d  = 1'b0;
          mask_d = 1'b1;
        end else if (step_req) begin
          mode_d = M_STEP;
          hbp_d  = 1'b0;
        end
      end
      M_STEP: begin
        d_d = last ? '0 : d_q + DW'(1);
        if (last) mode_d = M_HALT;
      end
      default: begin
        mode_d = M_HALT;
        d_d    = '0;
        pend_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Directed bench for cpu_clk_ctrl with small parameters: 4-cycle sampling
// tick, 2-tick debounce, 8-tick long press, 4-cycle CPU clock period.
module tb_cpu_clk_ctrl;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        btn;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [15:0] bus_addr;
  logic        cpu_clk;
  logic        cpu_tick;
  logic        running;
  logic        halted_bp;
  logic [15:0] step_cnt;

  int total = 0;
  int bad   = 0;

  cpu_clk_ctrl #(
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (2),
    .LONGPRESS_TICKS(8),
    .RUN_DIV        (4),
    .AUTORUN        (1),
    .ADDR_W         (16)
  ) dut (
    .sysclk   (sysclk),
    .rst_n    (rst_n),
    .btn      (btn),
    .bp_en    (bp_en),
    .bp_addr  (bp_addr),
    .bus_addr (bus_addr),
    .cpu_clk  (cpu_clk),
    .cpu_tick (cpu_tick),
    .running  (running),
    .halted_bp(halted_bp),
    .step_cnt (step_cnt)
  );

  // clock / reset block
  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every high phase of cpu_clk outside reset must last exactly RUN_DIV/2.
  int   hi_len   = 0;
  logic prev_clk = 1'b0;
  always @(negedge sysclk) begin
    if (!rst_n) begin
      hi_len   = 0;
      prev_clk = 1'b0;
    end else begin
      if (cpu_clk) hi_len++;
      else if (prev_clk) begin
        check("high_phase_len", 32'(hi_len), 32'd2);
        hi_len = 0;
      end
      prev_clk = cpu_clk;
    end
  end

  initial begin
    logic [15:0] cnt;
    logic [15:0] exp_v;
    logic        seen;
    int          ticks;

    rst_n    = 1'b0;
    btn      = 1'b0;
    bp_en    = 1'b0;
    bp_addr  = 16'h0000;
    bus_addr = 16'h0000;
    repeat (3) @(negedge sysclk);

    // reset state
    check("rst_cpu_clk",   32'(cpu_clk),   32'd0);
    check("rst_cpu_tick",  32'(cpu_tick),  32'd0);
    check("rst_running",   32'(running),   32'd1);
    check("rst_halted_bp", 32'(halted_bp), 32'd0);
    check("rst_step_cnt",  32'(step_cnt),  32'd0);

    // free run: 1100 pattern, tick on each rising edge
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sysclk);
      check("run_clk",  32'(cpu_clk),  ((k - 1) % 4 < 2) ? 32'd1 : 32'd0);
      check("run_tick", 32'(cpu_tick), ((k - 1) % 4 == 0) ? 32'd1 : 32'd0);
    end
    check("run_step_cnt", 32'(step_cnt), 32'd10);
    check("run_running",  32'(running),  32'd1);

    // long press from RUN -> HALT, no step on release
    btn  = 1'b1;
    seen = 1'b0;
    cnt  = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sysclk);
      if (i == 39) btn = 1'b0;
      if (!seen && !running) begin
        seen = 1'b1;
        cnt  = step_cnt;
      end
    end
    repeat (20) @(negedge sysclk);
    check("halt_seen",      32'(seen),      32'd1);
    check("halt_frozen",    32'(step_cnt),  32'(cnt));
    check("halt_running",   32'(running),   32'd0);
    check("halt_cpu_clk",   32'(cpu_clk),   32'd0);
    check("halt_halted_bp", 32'(halted_bp), 32'd0);

    // short press from HALT -> exactly one period
    cnt   = step_cnt;
    ticks = 0;
    btn   = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge sysclk);
      if (i == 15) btn = 1'b0;
      if (cpu_tick) ticks++;
    end
    check("step_ticks",   32'(ticks),    32'd1);
    check("step_cnt_inc", 32'(step_cnt), 32'(cnt + 16'd1));
    check("step_running", 32'(running),  32'd0);
    check("step_cpu_clk", 32'(cpu_clk),  32'd0);

    // one-tick glitch -> nothing
    cnt   = step_cnt;
    ticks = 0;
    btn   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge sysclk);
      if (i == 3) btn = 1'b0;
      if (cpu_tick) ticks++;
    end
    check("glitch_ticks", 32'(ticks),    32'd0);
    check("glitch_cnt",   32'(step_cnt), 32'(cnt));

    // long press HALT -> RUN, then breakpoint halt
    bp_en    = 1'b1;
    bp_addr  = 16'h0010;
    bus_addr = 16'h0000;
    btn      = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sysclk);
      if (i == 39) btn = 1'b0;
      if (running) seen = 1'b1;
    end
    check("resume_seen",      32'(seen),      32'd1);
    check("resume_running",   32'(running),   32'd1);
    check("resume_halted_bp", 32'(halted_bp), 32'd0);

    bus_addr = 16'h0010;
    repeat (12) @(negedge sysclk);
    check("bp_running",   32'(running),   32'd0);
    check("bp_halted_bp", 32'(halted_bp), 32'd1);
    check("bp_cpu_clk",   32'(cpu_clk),   32'd0);
    cnt = step_cnt;
    repeat (12) @(negedge sysclk);
    check("bp_frozen", 32'(step_cnt), 32'(cnt));

    // long press resumes even though the address still matches
    btn  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge sysclk);
      if (running) seen = 1'b1;
    end
    check("bp_resume_seen",      32'(seen),      32'd1);
    check("bp_resume_halted_bp", 32'(halted_bp), 32'd0);
    repeat (6) @(negedge sysclk);
    bus_addr = 16'h0000;
    repeat (30) @(negedge sysclk);
    btn = 1'b0;
    repeat (30) @(negedge sysclk);
    check("bp_resume_running",  32'(running),       32'd1);
    check("bp_resume_hbp_low",  32'(halted_bp),     32'd0);
    check("bp_resume_progress", 32'(step_cnt != cnt), 32'd1);

    // asynchronous reset in the middle of a high phase
    bp_en = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge sysclk);
      if (cpu_clk) seen = 1'b1;
    end
    check("mid_high_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_cpu_clk",   32'(cpu_clk),   32'd0);
    check("async_step_cnt",  32'(step_cnt),  32'd0);
    check("async_cpu_tick",  32'(cpu_tick),  32'd0);
    check("async_running",   32'(running),   32'd1);
    check("async_halted_bp", 32'(halted_bp), 32'd0);
    @(negedge sysclk);
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge sysclk);
      check("restart_clk",  32'(cpu_clk),  (k < 3) ? 32'd1 : 32'd0);
      check("restart_tick", 32'(cpu_tick), (k == 1) ? 32'd1 : 32'd0);
    end
    check("restart_step_cnt", 32'(step_cnt), 32'd1);

    // step_cnt wrap
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge sysclk);
      if (cpu_tick) seen = 1'b1;
    end
    check("wrap_tick_seen", 32'(seen), 32'd1);
    force dut.step_cnt = 16'hFFFE;
    #1;
    release dut.step_cnt;
    check("wrap_preload", 32'(step_cnt), 32'h0000FFFE);
    for (int j = 0; j < 3; j++) begin
      repeat (4) @(negedge sysclk);
      exp_v = 16'hFFFE + 16'(j + 1);
      check("wrap_tick", 32'(cpu_tick), 32'd1);
      check("wrap_cnt",  32'(step_cnt), 32'(exp_v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
